dmem_responder: RTL and testbench



---
 rtl/mips_mem_pkg.sv | 16 +
 rtl/dmem_array.sv | 22 ++
 rtl/dmem_responder.sv | 99 +++++++++
 tb/tb_dmem_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the M-stage data-memory responder:
// FSM encoding, legal latency range and word-index position within a byte address.
package mips_mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  localparam int unsigned LAT_MIN = 1;
  localparam int unsigned LAT_MAX = 15;

  // Byte-offset bits below the word index in ALUOutM.
  localparam int unsigned IDX_LSB = 2;

endpackage

// File: rtl/dmem_array.sv
// Single-port word array: synchronous write, combinational read.
// Contents are never reset.
module dmem_array #(
  parameter int unsigned AW        = 8,
  parameter string       INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wd,
  output logic [31:0]   rd
);

  logic [31:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wd;
  end

  assign rd = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the M stage: stalls the pipeline for
// LATENCY cycles per load/store, then presents load data for one cycle.
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned AW        = 8,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic        MemToRegM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallMem
);

  if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
    $error("dmem_responder: LATENCY must be within 1..15");
  end

  mem_state_t    st, st_nxt;
  logic [3:0]    cnt;
  logic [31:0]   rd_buf;
  logic          is_ld;

  logic          req;
  logic          ld_only;
  logic          we;
  logic [AW-1:0] idx;
  logic [31:0]   arr_rd;
  logic          unused_addr_bits;

  assign req     = MemWriteM | MemToRegM;
  assign ld_only = MemToRegM & ~MemWriteM;
  assign idx     = ALUOutM[AW+IDX_LSB-1:IDX_LSB];
  assign unused_addr_bits = ^{ALUOutM[31:AW+IDX_LSB], ALUOutM[IDX_LSB-1:0]};

  dmem_array #(
    .AW        (AW),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk  (clk),
    .we   (we),
    .addr (idx),
    .wd   (WriteDataM),
    .rd   (arr_rd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st     <= IDLE;
      cnt    <= '0;
      rd_buf <= '0;
      is_ld  <= 1'b0;
    end else begin
      st <= st_nxt;
      if (st == IDLE && req) begin
        cnt    <= 4'(LATENCY - 1);
        is_ld  <= ld_only;
        rd_buf <= ld_only ? arr_rd : '0;
      end else if (st == WAIT && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Reset also gates the outputs so they read zero while it is held,
  // even if a request is already waiting to be accepted.
  always_comb begin
    st_nxt    = st;
    StallMem  = 1'b0;
    ReadDataM = '0;
    we        = 1'b0;
    if (!reset) begin
      unique case (st)
        IDLE: begin
          if (req) begin
            StallMem = 1'b1;
            st_nxt   = WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            StallMem = 1'b1;
          end else begin
            st_nxt    = IDLE;
            ReadDataM = is_ld ? rd_buf : '0;
            we        = ~is_ld;
          end
        end
        default: st_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: two instances (LATENCY 2 and 1)
// compared against a word-array reference model with randomized traffic.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        mw    [2];
  logic        ml    [2];
  logic [31:0] addr  [2];
  logic [31:0] wd    [2];
  logic [31:0] rdata [2];
  logic        stall [2];

  int unsigned lat [2] = '{2, 1};
  logic [31:0] model [2][16];

  int n_checks = 0;
  int n_fail   = 0;

  dmem_responder #(.LATENCY(2), .AW(8), .INIT_FILE("")) dut_l2 (
    .clk(clk), .reset(reset), .MemWriteM(mw[0]), .MemToRegM(ml[0]),
    .ALUOutM(addr[0]), .WriteDataM(wd[0]), .ReadDataM(rdata[0]), .StallMem(stall[0])
  );

  dmem_responder #(.LATENCY(1), .AW(8), .INIT_FILE("")) dut_l1 (
    .clk(clk), .reset(reset), .MemWriteM(mw[1]), .MemToRegM(ml[1]),
    .ALUOutM(addr[1]), .WriteDataM(wd[1]), .ReadDataM(rdata[1]), .StallMem(stall[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one access on instance d (called #1 after a rising edge) and reports
  // the number of stall cycles, the data seen in the completion cycle, and whether
  // ReadDataM was non-zero while stalled. stalls = -1 means no completion seen.
  task automatic run_access(input int d, input bit w, input bit l,
                            input logic [31:0] a, input logic [31:0] wdat,
                            output int stalls, output logic [31:0] done_data,
                            output bit dirty);
    bit done;
    mw[d] = w; ml[d] = l; addr[d] = a; wd[d] = wdat;
    stalls = 0; dirty = 1'b0; done = 1'b0; done_data = 'x;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (stall[d] === 1'b1) begin
        stalls++;
        if (rdata[d] !== 32'h0) dirty = 1'b1;
      end else begin
        done_data = rdata[d];
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    mw[d] = 1'b0; ml[d] = 1'b0;
    if (!done) stalls = -1;
  endtask

  task automatic test_reset;
    int s; logic [31:0] dd; bit dirty;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      mw[d] = 1'b0; ml[d] = 1'b0; addr[d] = '0; wd[d] = '0;
    end
    #3;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (stall[d] !== 1'b0 || rdata[d] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d: stall=%b rdata=%h, required stall=0 rdata=0", d, stall[d], rdata[d]);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    ml[0] = 1'b1; addr[0] = 32'h0;
    @(posedge clk); #1;
    reset = 1'b0;
    run_access(0, 1'b0, 1'b1, 32'h0, 32'h0, s, dd, dirty);
    n_checks++;
    if (s !== int'(lat[0])) begin
      n_fail++;
      $display("FAIL reset_release_accept: stall cycles=%0d, required %0d", s, lat[0]);
    end
  endtask

  task automatic test_idle;
    for (int c = 0; c < 6; c++) begin
      for (int d = 0; d < 2; d++) begin
        mw[d] = 1'b0; ml[d] = 1'b0; addr[d] = $urandom; wd[d] = $urandom;
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (stall[d] !== 1'b0 || rdata[d] !== 32'h0) begin
          n_fail++;
          $display("FAIL idle_nonmem dut%0d cycle %0d: stall=%b rdata=%h, required 0/0", d, c, stall[d], rdata[d]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store_load;
    int s; logic [31:0] dd; bit dirty;
    run_access(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, s, dd, dirty);
    n_checks++;
    if (s !== 2 || dd !== 32'h0) begin
      n_fail++;
      $display("FAIL store_stall: stalls=%0d data=%h, required 2 and 0", s, dd);
    end
    model[0][4] = 32'hDEADBEEF;
    run_access(0, 1'b0, 1'b1, 32'h10, 32'h0, s, dd, dirty);
    n_checks++;
    if (s !== 2 || dd !== 32'hDEADBEEF || dirty) begin
      n_fail++;
      $display("FAIL load_after_store: stalls=%0d data=%h early=%b, required 2 DEADBEEF 0", s, dd, dirty);
    end
    @(negedge clk);
    n_checks++;
    if (rdata[0] !== 32'h0 || stall[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL data_one_cycle: rdata=%h stall=%b after completion, required 0/0", rdata[0], stall[0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap;
    int s1, s2; logic [31:0] d1, d2, v; bit dirty;
    v = $urandom;
    run_access(0, 1'b1, 1'b0, 32'h10, v, s1, d1, dirty);
    model[0][4] = v;
    run_access(0, 1'b0, 1'b1, 32'h13, 32'h0, s1, d1, dirty);
    run_access(0, 1'b0, 1'b1, 32'h10 + (32'd4 << 8), 32'h0, s2, d2, dirty);
    n_checks++;
    if (d1 !== model[0][4] || d2 !== model[0][4] || s1 !== 2 || s2 !== 2) begin
      n_fail++;
      $display("FAIL addr_wrap: d13=%h dwrap=%h stalls=%0d/%0d, required %h twice, 2/2", d1, d2, s1, s2, model[0][4]);
    end
  endtask

  task automatic test_back_to_back;
    int s; logic [31:0] dd; bit dirty;
    int pat [$];
    logic [31:0] got [2];
    for (int w = 0; w < 2; w++) begin
      model[1][w] = $urandom;
      run_access(1, 1'b1, 1'b0, 32'(w * 4), model[1][w], s, dd, dirty);
    end
    for (int w = 0; w < 2; w++) begin
      run_access(1, 1'b0, 1'b1, 32'(w * 4), 32'h0, s, dd, dirty);
      pat.push_back(s);
      got[w] = dd;
    end
    for (int w = 0; w < 2; w++) begin
      n_checks++;
      if (pat[w] !== 1 || got[w] !== model[1][w]) begin
        n_fail++;
        $display("FAIL b2b_load word %0d: stalls=%0d data=%h, required 1 %h", w, pat[w], got[w], model[1][w]);
      end
    end
  endtask

  task automatic test_reset_mid_store;
    int s; logic [31:0] dd, old; bit dirty;
    old = $urandom;
    run_access(0, 1'b1, 1'b0, 32'h20, old, s, dd, dirty);
    model[0][8] = old;
    mw[0] = 1'b1; ml[0] = 1'b0; addr[0] = 32'h20; wd[0] = 32'h12345678;
    @(posedge clk); #1;
    n_checks++;
    if (stall[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_stall: stall=%b in WAIT, required 1", stall[0]);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (stall[0] !== 1'b0 || rdata[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: stall=%b rdata=%h, required 0/0", stall[0], rdata[0]);
    end
    mw[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_access(0, 1'b0, 1'b1, 32'h20, 32'h0, s, dd, dirty);
    n_checks++;
    if (dd !== old || s !== 2) begin
      n_fail++;
      $display("FAIL store_discarded: data=%h stalls=%0d, required %h 2", dd, s, old);
    end
  endtask

  task automatic test_both_flags;
    int s; logic [31:0] dd; bit dirty;
    run_access(0, 1'b1, 1'b1, 32'h8, 32'hA5A5A5A5, s, dd, dirty);
    n_checks++;
    if (dd !== 32'h0 || s !== 2) begin
      n_fail++;
      $display("FAIL both_as_store: data=%h stalls=%0d, required 0 2", dd, s);
    end
    model[0][2] = 32'hA5A5A5A5;
    run_access(0, 1'b0, 1'b1, 32'h8, 32'h0, s, dd, dirty);
    n_checks++;
    if (dd !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL both_then_load: data=%h, required A5A5A5A5", dd);
    end
  endtask

  task automatic test_random;
    int s; logic [31:0] dd, v, a, exp_d; bit dirty; int d, w, kind;
    for (int dd_i = 0; dd_i < 2; dd_i++) begin
      for (int k = 0; k < 16; k++) begin
        model[dd_i][k] = $urandom;
        run_access(dd_i, 1'b1, 1'b0, 32'(k * 4), model[dd_i][k], s, dd, dirty);
      end
    end
    for (int n = 0; n < 30; n++) begin
      d    = int'($urandom_range(0, 1));
      w    = int'($urandom_range(0, 15));
      kind = int'($urandom_range(0, 2));
      v    = $urandom;
      a    = (32'(w) << 2) | 32'($urandom_range(0, 3)) | ($urandom << 10);
      exp_d = (kind == 1) ? model[d][w] : 32'h0;
      run_access(d, kind != 1, kind != 0, a, v, s, dd, dirty);
      if (kind != 1) model[d][w] = v;
      n_checks++;
      if (s !== int'(lat[d]) || dd !== exp_d || dirty) begin
        n_fail++;
        $display("FAIL random op %0d dut%0d kind %0d word %0d: stalls=%0d data=%h early=%b, required %0d %h 0",
                 n, d, kind, w, s, dd, dirty, lat[d], exp_d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_store_load();
    test_wrap();
    test_back_to_back();
    test_reset_mid_store();
    test_both_flags();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
